seg7_bcd_counter: RTL and testbench

Parametrised seconds/event counter with a multiplexed 7-segment display driver. A prescaler divides `clk` down to a count tick. A DIGITS-wide BCD counter steps on each tick: up or down, with hold and parallel load. The count is scanned onto a common-segment multi-digit display. The block sits directly behind the top-level pins and feeds the segment and digit-select outputs; it replaces the fixed single-digit seconds counter in earlier top-levels.

---
 rtl/seg7_bcd_counter.sv | 167 ++++++++++++++++
 tb/tb_seg7_bcd_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_counter.sv
// Prescaled up/down BCD counter with hold and parallel load, plus a scanned
// common-segment multi-digit 7-segment display driver.
module seg7_bcd_counter #(
  parameter int unsigned TICK_DIV       = 10_000_000,
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  hold,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int unsigned PreW  = $clog2(TICK_DIV);
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW  = 4 * DIGITS;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [PreW-1:0]   pre_q, pre_d;
  logic [ScanW-1:0]  scan_q, scan_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;

  logic              pre_wrap;
  logic              scan_wrap;
  logic [CntW-1:0]   step_val;
  logic              step_carry;
  logic [CntW-1:0]   load_clean;
  logic [3:0]        digit;
  logic [3:0]        cur_digit;

  // Ripple BCD step; step_carry ends high only when every digit rolled over.
  always_comb begin
    step_val   = count_q;
    step_carry = 1'b1;
    digit      = 4'd0;
    load_clean = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (step_carry) begin
        if (up_dn) begin
          if (digit == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            step_carry         = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            step_carry         = 1'b0;
          end
        end
      end
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  always_comb begin
    pre_d    = pre_q;
    count_d  = count_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    pre_wrap = (pre_q == PreW'(TICK_DIV - 1));
    if (load) begin
      count_d = load_clean;
      pre_d   = '0;
    end else if (en) begin
      pre_d  = pre_wrap ? '0 : pre_q + PreW'(1);
      tick_d = pre_wrap;
      if (pre_wrap && !hold) begin
        count_d = step_val;
        wrap_d  = step_carry;
      end
    end
  end

  always_comb begin
    scan_wrap = (scan_q == ScanW'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + ScanW'(1);
    idx_d     = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    dig_sel_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_digit    = count_q[4*i +: 4];
        dig_sel_d[i] = 1'b1;
      end
    end
    seg_d = seg_decode(cur_digit);
    // Blink the least-significant digit's point for the first half of each tick period.
    dp_d  = (idx_q == '0) && (32'(pre_q) < (TICK_DIV / 2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      seg_q     <= 7'h3F;
      dp_q      <= 1'b0;
      dig_sel_q <= DIGITS'(1);
    end else begin
      pre_q     <= pre_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign seg     = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp      = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
  assign dig_sel = SEG_ACTIVE_LOW ? ~dig_sel_q : dig_sel_q;

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Scoreboard bench: stimulus queues expected tick responses and display samples,
// a negedge monitor pops and compares them against an active-high and an active-low DUT.
module tb_seg7_bcd_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, hold, load;
  logic [7:0] load_val;
  logic [7:0] count0, count1;
  logic       tick0, tick1, wrap0, wrap1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [1:0] sel0, sel1;

  always #5 clk = ~clk;

  seg7_bcd_counter #(
    .TICK_DIV(4), .DIGITS(2), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .hold(hold), .load(load),
    .load_val(load_val), .count(count0), .tick(tick0), .wrap(wrap0), .seg(seg0),
    .dp(dp0), .dig_sel(sel0)
  );

  seg7_bcd_counter #(
    .TICK_DIV(4), .DIGITS(2), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_lo (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .hold(hold), .load(load),
    .load_val(load_val), .count(count1), .tick(tick1), .wrap(wrap1), .seg(seg1),
    .dp(dp1), .dig_sel(sel1)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  cnt;
    logic        wr;
  } tick_exp_t;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  sel;
    logic [6:0]  seg;
    logic        dp;
  } disp_exp_t;

  tick_exp_t   tq[$];
  disp_exp_t   dq[$];
  tick_exp_t   te;
  disp_exp_t   de;
  logic [1:0]  inv_sel;
  logic [6:0]  inv_seg;
  logic        inv_dp;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Cycle number since reset release: the edge that raises the first tick is cycle 4.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_tick(input int unsigned at, input logic [7:0] cnt, input logic wr);
    tick_exp_t e;
    e.cyc = at;
    e.cnt = cnt;
    e.wr  = wr;
    tq.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (tq.size() > 0 && !tick0 && tq[0].cyc < cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missed_tick: no tick by cyc %0d, required at cyc %0d", cyc, tq[0].cyc);
      void'(tq.pop_front());
    end
    if (tick0) begin
      if (tq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_tick: tick=1 at cyc %0d, required 0", cyc);
      end else begin
        te = tq.pop_front();
        check("tick_cycle", cyc, te.cyc);
        check("count_on_tick", count0, te.cnt);
        check("wrap_on_tick", wrap0, te.wr);
        check("count_on_tick_lo", count1, te.cnt);
        check("tick_lo", tick1, 1);
      end
    end
    if (wrap0 && !tick0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wrap_without_tick: wrap=1 tick=0 at cyc %0d, required wrap=0", cyc);
    end
    if (dq.size() > 0) begin
      if (dq[0].cyc == cyc) begin
        de      = dq.pop_front();
        inv_sel = ~de.sel;
        inv_seg = ~de.seg;
        inv_dp  = ~de.dp;
        check("dig_sel", sel0, de.sel);
        check("seg", seg0, de.seg);
        check("dp", dp0, de.dp);
        check("dig_sel_lo", sel1, inv_sel);
        check("seg_lo", seg1, inv_seg);
        check("dp_lo", dp1, inv_dp);
      end else if (dq[0].cyc < cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missed_display_sample: cyc %0d passed, required %0d", cyc, dq[0].cyc);
        void'(dq.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned c;
    disp_exp_t   d;
    int unsigned idx;
    int unsigned pre;

    reset = 1'b1; en = 1'b0; up_dn = 1'b1; hold = 1'b0; load = 1'b0; load_val = 8'h00;
    wait_cycles(3);
    check("rst_count", count0, 8'h00);
    check("rst_tick", tick0, 0);
    check("rst_wrap", wrap0, 0);
    check("rst_dig_sel", sel0, 2'b01);
    check("rst_seg", seg0, 7'h3F);
    check("rst_dp", dp0, 0);
    check("rst_dig_sel_lo", sel1, 2'b10);
    check("rst_seg_lo", seg1, 7'h40);
    check("rst_dp_lo", dp1, 1);

    // Count up 40 ticks from reset: ticks at cycles 4, 8, ..., 160.
    reset = 1'b0; en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      expect_tick(4 * k, 8'(((k / 10) << 4) | (k % 10)), 1'b0);
    end
    wait_cycles(160);
    check("count_after_40", count0, 8'h40);

    // Load 99, step up through the all-9s wrap.
    c = cyc;
    load = 1'b1; load_val = 8'h99;
    expect_tick(c + 5, 8'h00, 1'b1);
    expect_tick(c + 9, 8'h01, 1'b0);
    wait_cycles(1);
    load = 1'b0;
    check("load_99", count0, 8'h99);
    check("load_no_tick", tick0, 0);
    wait_cycles(8);

    // Load 00, step down through the all-0s wrap.
    c = cyc;
    load = 1'b1; load_val = 8'h00; up_dn = 1'b0;
    expect_tick(c + 5, 8'h99, 1'b1);
    expect_tick(c + 9, 8'h98, 1'b0);
    wait_cycles(1);
    load = 1'b0;
    check("load_00", count0, 8'h00);
    wait_cycles(8);

    // Load A7 when pre=3: load beats the wrap, next tick 4 cycles later.
    c = cyc;
    wait_cycles(3);
    load = 1'b1; load_val = 8'hA7; up_dn = 1'b1;
    expect_tick(c + 8, 8'h08, 1'b0);
    wait_cycles(1);
    load = 1'b0;
    check("load_a7_sanitised", count0, 8'h07);
    check("load_beats_wrap", tick0, 0);
    wait_cycles(4);

    // Hold across three ticks.
    c = cyc;
    hold = 1'b1;
    expect_tick(c + 4, 8'h08, 1'b0);
    expect_tick(c + 8, 8'h08, 1'b0);
    expect_tick(c + 12, 8'h08, 1'b0);
    wait_cycles(12);
    hold = 1'b0;

    // Freeze the prescaler at pre=2 for 20 cycles.
    c = cyc;
    wait_cycles(2);
    en = 1'b0;
    expect_tick(c + 24, 8'h09, 1'b0);
    wait_cycles(20);
    en = 1'b1;
    wait_cycles(2);

    // Display scan with count 42, held so the value stays put while pre runs.
    c = cyc;
    load = 1'b1; load_val = 8'h42; hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expect_tick(c + 1 + 4 * k, 8'h42, 1'b0);
    end
    for (int unsigned m = c + 3; m <= c + 18; m++) begin
      idx   = ((m - 1) / 2) % 2;
      pre   = (m - c - 2) % 4;
      d.cyc = m;
      d.sel = (idx == 0) ? 2'b01 : 2'b10;
      d.seg = (idx == 0) ? 7'h5B : 7'h66;
      d.dp  = (idx == 0) && (pre < 2);
      dq.push_back(d);
    end
    wait_cycles(1);
    load = 1'b0;
    check("load_42", count0, 8'h42);
    wait_cycles(19);

    // Reset with load, en and a pending prescaler wrap all active.
    hold = 1'b0;
    reset = 1'b1; load = 1'b1; load_val = 8'h55;
    wait_cycles(1);
    check("midrst_count", count0, 8'h00);
    check("midrst_tick", tick0, 0);
    check("midrst_wrap", wrap0, 0);
    check("midrst_dig_sel", sel0, 2'b01);
    check("midrst_seg", seg0, 7'h3F);
    check("midrst_dp", dp0, 0);
    reset = 1'b0; load = 1'b0; en = 1'b0;
    wait_cycles(2);

    check("tick_queue_drained", tq.size(), 0);
    check("display_queue_drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
